// File: rtl/p0_port_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : p0_port_pkg
// Brief    : Shared types and widths for the P0 command port (responder and
//            JTAG-side adapter).
// Revision : 1.0 - initial release
// ============================================================================
package p0_port_pkg;

    localparam int P0_ADDR_W = 22;
    localparam int P0_DATA_W = 16;
    localparam int P0_MASK_W = 2;

    // A fully masked slot is a read; idle JTAG slots therefore become refresh reads.
    localparam logic [P0_MASK_W-1:0] P0_READ_MASK = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_RDWAIT = 2'd2
    } p0_state_t;

    typedef struct packed {
        logic [P0_ADDR_W-1:0] addr;
        logic [P0_MASK_W-1:0] mask;
        logic [P0_DATA_W-1:0] wdata;
    } p0_cmd_t;

    function automatic logic is_read(input logic [P0_MASK_W-1:0] mask);
        return mask == P0_READ_MASK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/p0_port_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : p0_port_if
// Brief    : Request/acknowledge + read-valid bus towards the SDRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
interface p0_port_if
    import p0_port_pkg::*;
#(
    parameter int ADDR_W = P0_ADDR_W,
    parameter int DATA_W = P0_DATA_W
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/p0_port_responder_rd_timer.sv
`default_nettype none
// ============================================================================
// Module   : p0_rd_timer
// Brief    : Loadable read-timeout counter; flags expiry at RD_TIMEOUT-1.
// Revision : 1.0 - initial release
// ============================================================================
module p0_rd_timer #(
    parameter int RD_TIMEOUT = 12
) (
    input  wire logic MemClk,
    input  wire logic Reset,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expired
);
    localparam int CNT_W = ($clog2(RD_TIMEOUT) > 0) ? $clog2(RD_TIMEOUT) : 1;

    logic [CNT_W-1:0] r_count;

    assign o_expired = (r_count == CNT_W'(RD_TIMEOUT - 1));

    // Holds at the expiry value so a late enable can never wrap the count.
    always_ff @(posedge MemClk) begin
        if (!Reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/p0_port_responder.sv
`default_nettype none
// ============================================================================
// Module   : p0_port_responder
// Brief    : Samples one P0 command per slot and issues it to the SDRAM
//            controller, returning read data before the next slot.
// Revision : 1.0 - initial release
// ============================================================================
module p0_port_responder
    import p0_port_pkg::*;
#(
    parameter int                ADDR_W       = P0_ADDR_W,
    parameter int                DATA_W       = P0_DATA_W,
    parameter int                RD_TIMEOUT   = 12,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = 16'hDEAD
) (
    input  wire logic              MemClk,
    input  wire logic              Reset,
    input  wire logic              slot_start,
    input  wire logic [ADDR_W-1:0] P0_Address,
    input  wire logic [1:0]        P0_DQmask,
    input  wire logic [DATA_W-1:0] P0_DataWrite,
    output logic      [DATA_W-1:0] P0_DataRead,
    p0_port_if.master              mem,
    output logic                   overrun,
    output logic                   timeout,
    output logic      [7:0]        drop_cnt,
    input  wire logic              clr_status
);
    p0_state_t         r_state;
    p0_state_t         w_state_nxt;
    p0_cmd_t           r_cmd;
    logic [DATA_W-1:0] r_rdata;
    logic              r_overrun;
    logic              r_timeout;
    logic [7:0]        r_drop_cnt;

    logic              w_req;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic              w_timer_clear;
    logic              w_timer_en;
    logic              w_expired;
    logic              w_rd_done;
    logic              w_rd_to;
    logic              w_drop;
    logic              w_cmd_rd;

    assign w_cmd_rd = is_read(r_cmd.mask);
    assign w_drop   = slot_start && (r_state != ST_IDLE);

    p0_rd_timer #(
        .RD_TIMEOUT (RD_TIMEOUT)
    ) u_rd_timer (
        .MemClk    (MemClk),
        .Reset     (Reset),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge MemClk) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus outputs are decoded from state so they are zero whenever no request is live.
    always_comb begin
        w_state_nxt   = r_state;
        w_req         = 1'b0;
        w_we          = 1'b0;
        w_addr        = '0;
        w_be          = '0;
        w_wdata       = '0;
        w_timer_clear = 1'b0;
        w_timer_en    = 1'b0;
        w_rd_done     = 1'b0;
        w_rd_to       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (slot_start) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                w_req   = 1'b1;
                w_we    = !w_cmd_rd;
                w_addr  = r_cmd.addr;
                w_be    = w_cmd_rd ? 2'b11 : ~r_cmd.mask;
                w_wdata = r_cmd.wdata;
                if (mem.mem_ack) begin
                    w_timer_clear = 1'b1;
                    w_state_nxt   = w_cmd_rd ? ST_RDWAIT : ST_IDLE;
                end
            end
            ST_RDWAIT: begin
                w_timer_en = 1'b1;
                // Data arriving on the expiry cycle is still taken.
                if (mem.mem_rvalid) begin
                    w_rd_done   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_expired) begin
                    w_rd_to     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge MemClk) begin
        if (!Reset) begin
            r_cmd   <= '0;
            r_rdata <= '0;
        end else begin
            if ((r_state == ST_IDLE) && slot_start) begin
                r_cmd <= '{addr: P0_Address, mask: P0_DQmask, wdata: P0_DataWrite};
            end
            if (w_rd_done) begin
                r_rdata <= mem.mem_rdata;
            end else if (w_rd_to) begin
                r_rdata <= TIMEOUT_DATA;
            end
        end
    end

    always_ff @(posedge MemClk) begin
        if (!Reset || clr_status) begin
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_drop) begin
                r_overrun <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
            if (w_rd_to) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign mem.mem_req   = w_req;
    assign mem.mem_we    = w_we;
    assign mem.mem_addr  = w_addr;
    assign mem.mem_be    = w_be;
    assign mem.mem_wdata = w_wdata;
    assign P0_DataRead   = r_rdata;
    assign overrun       = r_overrun;
    assign timeout       = r_timeout;
    assign drop_cnt      = r_drop_cnt;
endmodule
`default_nettype wire

// File: tb/tb_p0_port_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_p0_port_responder
// Brief    : Randomized transaction-level check of p0_port_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_p0_port_responder;
    localparam int RD_TIMEOUT = 12;

    logic        MemClk;
    logic        Reset;
    logic        slot_start;
    logic [21:0] P0_Address;
    logic [1:0]  P0_DQmask;
    logic [15:0] P0_DataWrite;
    logic [15:0] P0_DataRead;
    logic        overrun;
    logic        timeout;
    logic [7:0]  drop_cnt;
    logic        clr_status;

    p0_port_if #(.ADDR_W(22), .DATA_W(16)) bus ();

    p0_port_responder #(
        .ADDR_W       (22),
        .DATA_W       (16),
        .RD_TIMEOUT   (RD_TIMEOUT),
        .TIMEOUT_DATA (16'hDEAD)
    ) dut (
        .MemClk       (MemClk),
        .Reset        (Reset),
        .slot_start   (slot_start),
        .P0_Address   (P0_Address),
        .P0_DQmask    (P0_DQmask),
        .P0_DataWrite (P0_DataWrite),
        .P0_DataRead  (P0_DataRead),
        .mem          (bus),
        .overrun      (overrun),
        .timeout      (timeout),
        .drop_cnt     (drop_cnt),
        .clr_status   (clr_status)
    );

    initial MemClk = 1'b0;
    always #5 MemClk = ~MemClk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_rdata;
    logic        exp_ovr;
    logic        exp_to;
    int          exp_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge MemClk);
        #1;
    endtask

    task automatic chk_status();
        chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
        chk("timeout", {31'd0, timeout}, {31'd0, exp_to});
        chk("drop_cnt", {24'd0, drop_cnt}, exp_drop);
    endtask

    task automatic chk_reset_state();
        chk("rst_req", {31'd0, bus.mem_req}, 0);
        chk("rst_we", {31'd0, bus.mem_we}, 0);
        chk("rst_addr", {10'd0, bus.mem_addr}, 0);
        chk("rst_be", {30'd0, bus.mem_be}, 0);
        chk("rst_wdata", {16'd0, bus.mem_wdata}, 0);
        chk("rst_rdata", {16'd0, P0_DataRead}, 0);
        chk_status();
    endtask

    // Status model: a clear beats a simultaneous drop; drops saturate at 255.
    task automatic model_status(input bit drop, input bit clr);
        if (clr) begin
            exp_ovr = 1'b0; exp_to = 1'b0; exp_drop = 0;
        end else if (drop) begin
            exp_ovr = 1'b1;
            if (exp_drop < 255) exp_drop++;
        end
    endtask

    // One slot: capture, request with ack delay, optional read return or timeout.
    task automatic run_slot(input logic [21:0] a, input logic [1:0] m, input logic [15:0] d,
                            input int ack_dly, input int rv_dly, input logic [15:0] rdat,
                            input bit inj, input bit clr);
        bit          rd;
        logic [1:0]  be_exp;
        rd     = (m == 2'b11);
        be_exp = rd ? 2'b11 : ~m;
        slot_start = 1'b1; P0_Address = a; P0_DQmask = m; P0_DataWrite = d;
        tick();
        slot_start   = 1'b0;
        P0_Address   = 22'($urandom);
        P0_DQmask    = 2'($urandom);
        P0_DataWrite = 16'($urandom);
        for (int k = 0; k <= ack_dly; k++) begin
            chk("req", {31'd0, bus.mem_req}, 1);
            chk("we", {31'd0, bus.mem_we}, {31'd0, !rd});
            chk("addr", {10'd0, bus.mem_addr}, {10'd0, a});
            chk("be", {30'd0, bus.mem_be}, {30'd0, be_exp});
            if (!rd) chk("wdata", {16'd0, bus.mem_wdata}, {16'd0, d});
            if (k == ack_dly) begin
                bus.mem_ack = 1'b1; slot_start = inj; clr_status = clr;
            end
            tick();
        end
        bus.mem_ack = 1'b0; slot_start = 1'b0; clr_status = 1'b0;
        model_status(inj, clr);
        chk("req_after_ack", {31'd0, bus.mem_req}, 0);
        if (rd) begin
            if (rv_dly < RD_TIMEOUT) begin
                repeat (rv_dly) tick();
                bus.mem_rvalid = 1'b1; bus.mem_rdata = rdat;
                tick();
                bus.mem_rvalid = 1'b0;
                exp_rdata = rdat;
            end else begin
                repeat (RD_TIMEOUT) tick();
                exp_rdata = 16'hDEAD;
                exp_to    = 1'b1;
                chk("to_rdata", {16'd0, P0_DataRead}, {16'd0, exp_rdata});
                bus.mem_rvalid = 1'b1; bus.mem_rdata = rdat;
                tick();
                bus.mem_rvalid = 1'b0;
            end
        end
        chk("rdata", {16'd0, P0_DataRead}, {16'd0, exp_rdata});
        chk_status();
        chk("idle_req", {31'd0, bus.mem_req}, 0);
    endtask

    initial begin
        Reset = 1'b0; slot_start = 1'b0; clr_status = 1'b0;
        P0_Address = '0; P0_DQmask = '0; P0_DataWrite = '0;
        bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        exp_rdata = '0; exp_ovr = 1'b0; exp_to = 1'b0; exp_drop = 0;
        tick(); tick();
        chk_reset_state();
        Reset = 1'b1;
        tick();

        run_slot(22'h000123, 2'b00, 16'hA55A, 0, 0, 16'h0000, 1'b0, 1'b0);
        run_slot(22'h0ABCDE, 2'b01, 16'h1234, 3, 0, 16'h0000, 1'b0, 1'b0);
        run_slot(22'h3FFFFF, 2'b11, 16'h0000, 0, 4, 16'hBEEF, 1'b0, 1'b0);
        run_slot(22'h000042, 2'b10, 16'h5678, 1, 0, 16'h0000, 1'b0, 1'b0);
        run_slot(22'h155555, 2'b11, 16'h0000, 1, 20, 16'h7777, 1'b0, 1'b0);
        run_slot(22'h2AAAAA, 2'b11, 16'h0000, 0, RD_TIMEOUT - 1, 16'hC0DE, 1'b0, 1'b0);
        run_slot(22'h000777, 2'b00, 16'h9999, 2, 0, 16'h0000, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++)
            run_slot(22'($urandom), 2'b00, 16'($urandom), 0, 0, 16'h0, 1'b1, 1'b0);
        run_slot(22'h001000, 2'b11, 16'h0000, 0, 2, 16'h4321, 1'b1, 1'b1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        model_status(1'b0, 1'b1);
        chk_status();

        // Reset while a read is outstanding.
        slot_start = 1'b1; P0_Address = 22'h012345; P0_DQmask = 2'b11;
        tick();
        slot_start = 1'b0; bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        exp_rdata = '0; exp_ovr = 1'b0; exp_to = 1'b0; exp_drop = 0;
        chk_reset_state();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'h6666;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("stray_rvalid", {16'd0, P0_DataRead}, 0);
        run_slot(22'h0F0F0F, 2'b11, 16'h0000, 1, 3, 16'hFACE, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++)
            run_slot(22'($urandom), 2'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 15)), 16'($urandom),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
